// File: rtl/alu_mp_seq.sv
// Byte-serial multi-precision add/subtract sequencer built around one 8-bit ripple ALU.
// Inter-byte carries are resolved with an extra increment pass because the ALU has no carry-in.

module alu8 (
   input  logic [7:0] x,
   input  logic [7:0] y,
   input  logic [2:0] sel,
   output logic [7:0] sum,
   output logic       carry
);
   logic [7:0] yy;
   logic [7:0] s;
   logic       cy;

   always_comb begin
      yy = (sel == 3'b001) ? ~y : y;
      cy = (sel == 3'b001);
      s  = '0;
      for (int i = 0; i < 8; i++) begin
         s[i] = x[i] ^ yy[i] ^ cy;
         cy   = (x[i] & yy[i]) | (cy & (x[i] ^ yy[i]));
      end
      sum   = s;
      carry = cy;
      case (sel)
         3'b010: begin sum = x & y; carry = 1'b0; end
         3'b011: begin sum = x | y; carry = 1'b0; end
         3'b100: begin sum = x ^ y; carry = 1'b0; end
         default: ;
      endcase
   end
endmodule

module alu_mp_seq #(
   parameter int NBYTES = 4,
   localparam int W = 8 * NBYTES
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result,
   output logic         cout,
   output logic         ovf
);
   localparam int IW = $clog2(NBYTES);
   localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

   typedef enum logic [1:0] {IDLE, ADD, INC, DONE} state_t;

   state_t        state;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic [IW-1:0] idx;
   logic          carry;
   logic [7:0]    tmp;
   logic          tc;

   logic [7:0]    alu_x;
   logic [7:0]    alu_y;
   logic [7:0]    alu_sum;
   logic          alu_c;
   logic          adv;
   logic          wr_carry;

   always_comb begin
      alu_x    = a_q[{idx, 3'b000} +: 8];
      alu_y    = b_q[{idx, 3'b000} +: 8];
      adv      = 1'b0;
      wr_carry = alu_c;
      if (state == INC) begin
         alu_x    = tmp;
         alu_y    = 8'h01;
         adv      = 1'b1;
         // tc and the increment carry are mutually exclusive, so OR is exact.
         wr_carry = tc | alu_c;
      end else if (state == ADD && !carry) begin
         adv = 1'b1;
      end
   end

   alu8 u_alu (
      .x     (alu_x),
      .y     (alu_y),
      .sel   (3'b000),
      .sum   (alu_sum),
      .carry (alu_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_q    <= '0;
         b_q    <= '0;
         idx    <= '0;
         carry  <= 1'b0;
         tmp    <= '0;
         tc     <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  a_q    <= a;
                  b_q    <= op ? ~b : b;
                  carry  <= op;
                  idx    <= '0;
                  result <= '0;
                  cout   <= 1'b0;
                  ovf    <= 1'b0;
                  busy   <= 1'b1;
                  state  <= ADD;
               end else begin
                  state <= IDLE;
               end
            end
            ADD: begin
               if (carry) begin
                  tmp   <= alu_sum;
                  tc    <= alu_c;
                  state <= INC;
               end
            end
            default: ;
         endcase

         if (adv) begin
            result[{idx, 3'b000} +: 8] <= alu_sum;
            carry                      <= wr_carry;
            if (idx == LAST) begin
               cout  <= wr_carry;
               // alu_sum[7] is the result MSB being written on this edge.
               ovf   <= (a_q[W-1] == b_q[W-1]) && (alu_sum[7] != a_q[W-1]);
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= DONE;
            end else begin
               idx   <= idx + IW'(1);
               state <= ADD;
            end
         end
      end
   end
endmodule

// File: tb/tb_alu_mp_seq.sv
// Directed bench for alu_mp_seq: vector table plus reset, ignored-start and back-to-back sequences.

module tb_alu_mp_seq;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         op = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;

   int tests_run = 0;
   int tests_failed = 0;

   typedef struct {
      logic         op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         cout;
      logic         ovf;
      int           k;
   } vec_t;

   vec_t vecs[9];

   alu_mp_seq #(.NBYTES(4)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout),
      .ovf    (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drives start for one edge (E0); returns #1 after E0.
   task automatic launch(input logic o, input logic [W-1:0] av, input logic [W-1:0] bv);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      a     = av;
      b     = bv;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Called #1 after E0; returns #1 after the edge on which done rose.
   task automatic wait_done(output int k, output int busy_cnt);
      k = 0;
      busy_cnt = 0;
      while (!done && k < 30) begin
         if (busy) busy_cnt++;
         @(posedge clk);
         #1;
         k++;
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int k;
      int bc;
      launch(v.op, v.a, v.b);
      wait_done(k, bc);
      check({tag, " done_seen"}, 64'(done), 64'(1));
      check({tag, " latency"}, 64'(k), 64'(v.k));
      check({tag, " busy_cycles"}, 64'(bc), 64'(v.k));
      check({tag, " busy_at_done"}, 64'(busy), 64'(0));
      check({tag, " result"}, 64'(result), 64'(v.res));
      check({tag, " cout"}, 64'(cout), 64'(v.cout));
      check({tag, " ovf"}, 64'(ovf), 64'(v.ovf));
   endtask

   initial begin
      int k;
      int bc;
      logic [W-1:0] held;

      vecs[0] = '{1'b0, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0, 4};
      vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 7};
      vecs[2] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 7};
      vecs[3] = '{1'b1, 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b1, 1'b0, 8};
      vecs[4] = '{1'b1, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0, 5};
      vecs[5] = '{1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 5};
      vecs[6] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 5};
      vecs[7] = '{1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0, 4};
      vecs[8] = '{1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0, 5};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst busy", 64'(busy), 64'(0));
      check("rst done", 64'(done), 64'(0));
      check("rst result", 64'(result), 64'(0));
      check("rst cout", 64'(cout), 64'(0));
      check("rst ovf", 64'(ovf), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Outputs hold after done until the next accepted start
      held = result;
      repeat (3) @(posedge clk);
      #1;
      check("hold result", 64'(result), 64'(held));
      check("hold done", 64'(done), 64'(0));
      check("hold busy", 64'(busy), 64'(0));

      // Asynchronous reset during the 2nd ADD cycle aborts without done
      launch(1'b0, 32'h0000_0001, 32'h0000_0002);
      @(posedge clk);
      #2;
      check("midrst busy_before", 64'(busy), 64'(1));
      rst_n = 1'b0;
      #1;
      check("midrst busy", 64'(busy), 64'(0));
      check("midrst result", 64'(result), 64'(0));
      check("midrst cout", 64'(cout), 64'(0));
      check("midrst ovf", 64'(ovf), 64'(0));
      k = 0;
      repeat (2) begin
         @(posedge clk);
         #1;
         if (done) k++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (done || busy) k++;
      end
      check("midrst no_done", 64'(k), 64'(0));
      run_vec(vecs[0], "after_rst");

      // start while busy is ignored
      launch(1'b0, 32'h0000_0001, 32'h0000_0002);
      @(negedge clk);
      start = 1'b1;
      op    = 1'b1;
      a     = 32'hDEAD_BEEF;
      b     = 32'h1234_5678;
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      wait_done(k, bc);
      check("ignore done_seen", 64'(done), 64'(1));
      check("ignore latency", 64'(k + 2), 64'(4));
      check("ignore result", 64'(result), 64'(32'h0000_0003));
      check("ignore cout", 64'(cout), 64'(0));

      // Back-to-back: start asserted in the DONE cycle
      launch(1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
      wait_done(k, bc);
      check("b2b first_done", 64'(done), 64'(1));
      check("b2b first_result", 64'(result), 64'(32'h0000_0000));
      start = 1'b1;
      op    = 1'b1;
      a     = 32'h0000_0005;
      b     = 32'h0000_0003;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("b2b busy_rise", 64'(busy), 64'(1));
      check("b2b done_low", 64'(done), 64'(0));
      wait_done(k, bc);
      check("b2b second_done", 64'(done), 64'(1));
      check("b2b second_latency", 64'(k), 64'(8));
      check("b2b second_result", 64'(result), 64'(32'h0000_0002));
      check("b2b second_cout", 64'(cout), 64'(1));
      @(posedge clk);
      #1;
      check("b2b idle_after", 64'(done), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/alu_mp_seq.md
Name: alu_mp_seq

Overview:
- Byte-serial multi-precision add/subtract sequencer.
- Instantiates one 8-bit ripple ALU and time-multiplexes it over NBYTES operand bytes, LSB first.
- The ALU has no carry-in, so the sequencer resolves inter-byte carries itself with an extra increment pass.
- Sits between the register file/control FSM and the 8-bit ALU datapath; uses a start/busy/done handshake.

Parameters:
NBYTES, 4, operand width in bytes (W = 8*NBYTES); legal range 2..8

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous assert, active-low
start  input  1  request; sampled on the rising edge; accepted only when busy=0
op  input  1  0 = A+B, 1 = A-B; sampled with start
a  input  W  operand A; sampled with start
b  input  W  operand B; sampled with start
busy  output  1  high while in ADD or INC state
done  output  1  one-cycle pulse; result, cout and ovf valid
result  output  W  sum/difference
cout  output  1  carry out of MSB (for subtract, 1 = no borrow)
ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, result=0, cout=0, ovf=0; internal byte index, carry and temp registers cleared. Reset during ADD/INC aborts the operation immediately; no done is produced.
- ALU usage: sel is tied to 3'b000 (add). Subtraction is never delegated to the ALU's sel. It is formed as A + ~B + 1.
- States:
  - IDLE/DONE: busy=0.
  - ADD, INC: busy=1.
- Accepting start (state IDLE or DONE, start=1 at edge E0):
  - latch A; latch Beff = op ? ~b : b
  - carry = op; idx = 0; clear result/cout/ovf
  - go to ADD
- start while busy=1 is ignored; latched operands are unaffected.
- ADD (byte idx):
  - ALU x = A[idx], y = Beff[idx]; capture s = sum, c1 = carry.
  - If carry=1: tmp = s, tc = c1, go to INC.
  - Else: result[idx] = s, carry = c1, then advance.
- INC:
  - ALU x = tmp, y = 8'h01.
  - result[idx] = sum; carry = tc | alu_carry (both can never be 1 together); advance.
- Advance:
  - If idx < NBYTES-1: idx++, go to ADD.
  - Else: cout = carry; ovf = (A[W-1] == Beff[W-1]) && (result[W-1] != A[W-1]); go to DONE.
- DONE: lasts exactly one cycle with done=1.
  - Without start, next state is IDLE.
  - With start, the new operation is accepted in the same edge, so back-to-back operations are allowed.
- Latency: done is high in the cycle beginning at edge E0+K, where K = NBYTES + (number of INC passes). For the default NBYTES=4:
  - add: K ranges 4..7
  - sub: K ranges 5..8, because byte 0 always takes an INC pass
- result, cout and ovf hold their values after DONE until the next accepted start. result is not valid while busy=1.
- start and rst_n deassertion in the same cycle: reset wins while rst_n=0; start is sampled only on edges where rst_n=1.

Test Plan:
- Reset mid-operation:
  - Add 1+2, assert rst_n=0 during the 2nd ADD cycle.
  - Outputs go to 0 immediately, no done pulse.
  - After release the next op works normally.
- Simple add:
  - a=0x00000001, b=0x00000002, op=0.
  - done at E0+4; result=0x00000003, cout=0, ovf=0.
  - busy high for exactly 4 cycles.
- Full carry ripple:
  - a=0xFFFFFFFF, b=0x00000001, op=0.
  - done at E0+7; result=0x00000000, cout=1, ovf=0.
- Signed overflow:
  - a=0x7FFFFFFF, b=0x00000001, op=0.
  - done at E0+7; result=0x80000000, cout=0, ovf=1.
- Subtract:
  - a=0x00000005, b=0x00000003, op=1: done at E0+8; result=0x00000002, cout=1, ovf=0.
  - a=3, b=5, op=1: result=0xFFFFFFFE, cout=0, ovf=0.
- Handshake:
  - Pulse start again mid-operation with different operands; it is ignored and the first result is unchanged.
  - Assert start in the DONE cycle; the new op is accepted with zero idle cycles and busy rises on the next cycle.
